// File: rtl/cmos_pkg.sv
// Shared types and word layout for the CMOS capture front end.
package cmos_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int LO_PIX_LSB = 0;
  localparam int LO_PIX_MSB = 15;
  localparam int HI_PIX_LSB = 16;
  localparam int HI_PIX_MSB = 31;

  function automatic logic [31:0] pack_pair(input logic [15:0] lo, input logic [15:0] hi);
    logic [31:0] w;
    w = '0;
    w[LO_PIX_MSB:LO_PIX_LSB] = lo;
    w[HI_PIX_MSB:HI_PIX_LSB] = hi;
    return w;
  endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Registered edge detector for a sync line of configurable active level.
// rise is combinational from the live input: high for the single cycle the line enters its active level.
module cmos_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic rise
);

  logic level;
  logic level_q;

  assign level = (sync == POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/cmos_frame_packer.sv
// Captures one armed frame between two VSYNC rises, packs pixel pairs into 32-bit words with SOF/EOF.
// Words emerge one completion (or the closing VSYNC) after being staged; a push into a busy output register is dropped and flagged.
module cmos_frame_packer
  import cmos_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter bit VSYNC_POL = 1'b1,
  parameter bit HSYNC_POL = 1'b1
) (
  input  logic             cmos_clk_i,
  input  logic             cmos_rst_i,
  input  logic [15:0]      cmos_data_i,
  input  logic             cmos_vsync_i,
  input  logic             cmos_hsync_i,
  input  logic             cmos_valid_i,
  input  logic             arm_i,
  input  logic             abort_i,
  output logic [31:0]      out_dat_o,
  output logic             out_sof_o,
  output logic             out_eof_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             odd_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  state_t      state;
  state_t      state_nxt;
  logic        vs_rise;
  logic        hs_rise;
  logic [15:0] half_dat;
  logic        half_vld;
  logic [31:0] stg_dat;
  logic        stg_vld;
  logic        stg_sof;
  logic        sof_pend;
  logic        push;
  logic        push_eof;
  logic        clr;
  logic        out_free;

  cmos_sync_edge #(.POL(VSYNC_POL)) u_vs_edge (
    .clk  (cmos_clk_i),
    .rst  (cmos_rst_i),
    .sync (cmos_vsync_i),
    .rise (vs_rise)
  );

  cmos_sync_edge #(.POL(HSYNC_POL)) u_hs_edge (
    .clk  (cmos_clk_i),
    .rst  (cmos_rst_i),
    .sync (cmos_hsync_i),
    .rise (hs_rise)
  );

  assign out_free = ~out_valid_o | out_ready_i;
  assign busy_o   = (state == WAIT_SOF) || (state == CAPTURE);
  assign done_o   = (state == DONE);

  always_ff @(posedge cmos_clk_i or posedge cmos_rst_i) begin
    if (cmos_rst_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_eof  = 1'b0;
    clr       = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_i) begin
            state_nxt = WAIT_SOF;
            clr       = 1'b1;
          end
        end
        WAIT_SOF: begin
          if (vs_rise) state_nxt = CAPTURE;
        end
        CAPTURE: begin
          if (vs_rise) begin
            state_nxt = DONE;
            push      = stg_vld;
            push_eof  = 1'b1;
          end else if (cmos_valid_i && half_vld && stg_vld) begin
            // a new word completes while one is still staged: the staged one leaves first
            push = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge cmos_clk_i or posedge cmos_rst_i) begin
    if (cmos_rst_i) begin
      out_dat_o   <= '0;
      out_sof_o   <= 1'b0;
      out_eof_o   <= 1'b0;
      out_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      odd_o       <= 1'b0;
      frame_cnt_o <= '0;
      line_cnt_o  <= '0;
      word_cnt_o  <= '0;
      half_dat    <= '0;
      half_vld    <= 1'b0;
      stg_dat     <= '0;
      stg_vld     <= 1'b0;
      stg_sof     <= 1'b0;
      sof_pend    <= 1'b0;
    end else begin
      if (vs_rise) frame_cnt_o <= frame_cnt_o + CNT_W'(1);

      if (out_ready_i) out_valid_o <= 1'b0;
      if (push) begin
        if (out_free) begin
          out_valid_o <= 1'b1;
          out_dat_o   <= stg_dat;
          out_sof_o   <= stg_sof;
          out_eof_o   <= push_eof;
          if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + CNT_W'(1);
        end else begin
          overflow_o <= 1'b1;
        end
      end

      if (state == CAPTURE && hs_rise && line_cnt_o != '1)
        line_cnt_o <= line_cnt_o + CNT_W'(1);

      if (clr) begin
        overflow_o <= 1'b0;
        odd_o      <= 1'b0;
        line_cnt_o <= '0;
        word_cnt_o <= '0;
      end

      if (abort_i) begin
        half_vld <= 1'b0;
        stg_vld  <= 1'b0;
      end else if (state == WAIT_SOF && vs_rise) begin
        half_vld <= cmos_valid_i;
        half_dat <= cmos_data_i;
        stg_vld  <= 1'b0;
        sof_pend <= 1'b1;
      end else if (state == CAPTURE) begin
        if (vs_rise) begin
          half_vld <= 1'b0;
          stg_vld  <= 1'b0;
          if (half_vld) odd_o <= 1'b1;
        end else if (cmos_valid_i) begin
          if (!half_vld) begin
            half_dat <= cmos_data_i;
            half_vld <= 1'b1;
          end else begin
            half_vld <= 1'b0;
            stg_dat  <= pack_pair(half_dat, cmos_data_i);
            stg_vld  <= 1'b1;
            stg_sof  <= sof_pend;
            sof_pend <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Randomised frame stimulus against a pixel-pairing reference model with a decoupled output scoreboard.
module tb_cmos_frame_packer;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cmos_data = '0;
  logic          cmos_vsync = 1'b0;
  logic          cmos_hsync = 1'b0;
  logic          cmos_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic [31:0]   out_dat;
  logic          out_sof, out_eof, out_valid;
  logic          busy, done, overflow, odd;
  logic [CW-1:0] frame_cnt, line_cnt, word_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // expected output words: {eof, sof, data}
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  // reference model state
  int          m_frame = 0, m_line = 0, m_word = 0, m_ovf = 0, m_odd = 0, m_done = 0;
  int          px_cnt = 0;
  logic [15:0] px_half = '0;
  logic [31:0] w_pend = '0;
  bit          w_have = 0, w_first = 0, stall_mode = 0, held = 0;

  cmos_frame_packer #(.CNT_W(CW)) dut (
    .cmos_clk_i   (clk),
    .cmos_rst_i   (rst),
    .cmos_data_i  (cmos_data),
    .cmos_vsync_i (cmos_vsync),
    .cmos_hsync_i (cmos_hsync),
    .cmos_valid_i (cmos_valid),
    .arm_i        (arm),
    .abort_i      (abort),
    .out_dat_o    (out_dat),
    .out_sof_o    (out_sof),
    .out_eof_o    (out_eof),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow),
    .odd_o        (odd),
    .frame_cnt_o  (frame_cnt),
    .line_cnt_o   (line_cnt),
    .word_cnt_o   (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output word must be the next expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_word: got unexpected %h sof=%b eof=%b, required no word", out_dat, out_sof, out_eof);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_eof, out_sof, out_dat} !== mon_exp) begin
          n_err++;
          $display("FAIL out_word: got %h sof=%b eof=%b, required %h sof=%b eof=%b",
                   out_dat, out_sof, out_eof, mon_exp[31:0], mon_exp[32], mon_exp[33]);
        end
      end
    end
  end

  task automatic drive(input logic [15:0] d, input logic vs, input logic hs, input logic v);
    cmos_data  = d;
    cmos_vsync = vs;
    cmos_hsync = hs;
    cmos_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Output register holds one word; with the sink stalled, any further word is lost.
  task automatic release_word(input logic [31:0] w, input bit eof);
    if (stall_mode && held) begin
      m_ovf = 1;
    end else begin
      exp_q.push_back({eof, w_first, w});
      w_first = 0;
      held    = 1;
      if (m_word < SAT) m_word++;
    end
  endtask

  // Pixels pair up in arrival order; a finished word is only released once the next one finishes.
  task automatic model_pixel(input logic [15:0] d);
    if (px_cnt % 2 == 1) begin
      if (w_have) release_word(w_pend, 1'b0);
      w_pend = {d, px_half};
      w_have = 1;
    end else begin
      px_half = d;
    end
    px_cnt++;
  endtask

  task automatic model_clear();
    px_cnt  = 0;
    w_have  = 0;
    w_first = 1;
    held    = 0;
  endtask

  task automatic do_arm();
    m_ovf = 0; m_odd = 0; m_line = 0; m_word = 0; m_done = 0;
    model_clear();
    arm = 1'b1;
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    arm = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"},  int'(busy),      0);
    chk({tag, "_done"},  int'(done),      m_done);
    chk({tag, "_lines"}, int'(line_cnt),  m_line);
    chk({tag, "_words"}, int'(word_cnt),  m_word);
    chk({tag, "_ovf"},   int'(overflow),  m_ovf);
    chk({tag, "_odd"},   int'(odd),       m_odd);
    chk({tag, "_frame"}, int'(frame_cnt), m_frame);
  endtask

  // ppl > 0: every line carries ppl back-to-back pixels numbered from 1; ppl == 0: random lines.
  task automatic send_frame(input string tag, input bit armed, input int nlines, input int ppl,
                            input bit pix_start, input bit pix_end, input bit stall);
    logic [15:0] d;
    logic        v;
    int          len;
    logic [15:0] seq;
    seq        = 16'd1;
    stall_mode = stall;
    if (armed) do_arm();
    out_ready = !stall;
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    if (armed && pix_start) model_pixel(16'hAAAA);
    m_frame = (m_frame + 1) % (SAT + 1);
    drive(16'hAAAA, 1'b1, 1'b0, pix_start);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      len = (ppl > 0) ? ppl : int'($urandom_range(1, 6));
      if (armed && m_line < SAT) m_line++;
      for (int p = 0; p < len; p++) begin
        if (ppl > 0) begin
          v = 1'b1; d = seq; seq = seq + 16'd1;
        end else begin
          v = 1'($urandom_range(0, 1)); d = 16'($urandom);
        end
        if (armed && v) model_pixel(d);
        drive(d, 1'b0, 1'b1, v);
      end
      drive(16'h0, 1'b0, 1'b0, 1'b0);
      drive(16'h0, 1'b0, 1'b0, 1'b0);
    end
    if (armed) begin
      if (w_have) release_word(w_pend, 1'b1);
      w_have = 0;
      if (px_cnt % 2 == 1) m_odd = 1;
      m_done = 1;
    end
    m_frame = (m_frame + 1) % (SAT + 1);
    drive(16'hAAAA, 1'b1, 1'b0, pix_end);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(16'h0, 1'b0, 1'b0, 1'b0);
    check_status(tag);
    if (stall) begin
      out_ready = 1'b1;
      repeat (3) drive(16'h0, 1'b0, 1'b0, 1'b0);
    end
    stall_mode = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset_flags", int'({out_valid, out_sof, out_eof, busy, done, overflow, odd}), 0);
    chk("reset_dat", int'(out_dat), 0);
    chk("reset_cnts", int'({frame_cnt, line_cnt, word_cnt}), 0);
    rst = 1'b0;
    repeat (2) drive(16'h0, 1'b0, 1'b0, 1'b0);

    send_frame("f4x2", 1'b1, 2, 4, 1'b0, 1'b0, 1'b0);
    send_frame("noarm", 1'b0, 3, 0, 1'b0, 1'b0, 1'b0);
    send_frame("stall", 1'b1, 2, 4, 1'b0, 1'b0, 1'b1);
    send_frame("odd5", 1'b1, 1, 5, 1'b0, 1'b0, 1'b0);

    // abort part-way through a frame: the staged word and pending half-word vanish
    do_arm();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    m_frame = (m_frame + 1) % (SAT + 1);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    m_line = 1;
    for (int p = 0; p < 3; p++) begin
      model_pixel(16'h0100 + 16'(p));
      drive(16'h0100 + 16'(p), 1'b0, 1'b1, 1'b1);
    end
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    model_clear();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    m_frame = (m_frame + 1) % (SAT + 1);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    check_status("post_abort");
    send_frame("rearm", 1'b1, 3, 0, 1'b0, 1'b0, 1'b0);

    send_frame("edge_pix", 1'b1, 2, 3, 1'b1, 1'b1, 1'b0);
    send_frame("word_sat", 1'b1, 1, 36, 1'b0, 1'b0, 1'b0);
    send_frame("line_sat", 1'b1, 18, 2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      send_frame("rand", $urandom_range(0, 3) != 0, int'($urandom_range(1, 8)), 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // asynchronous reset in the middle of a capture
    do_arm();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    m_frame = (m_frame + 1) % (SAT + 1);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b1, 1'b0, 1'b0);
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      model_pixel(16'h0200 + 16'(p));
      drive(16'h0200 + 16'(p), 1'b0, 1'b1, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_flags", int'({out_valid, out_sof, out_eof, busy, done, overflow, odd}), 0);
    chk("arst_dat", int'(out_dat), 0);
    chk("arst_cnts", int'({frame_cnt, line_cnt, word_cnt}), 0);
    exp_q.delete();
    m_frame = 0; m_line = 0; m_word = 0; m_ovf = 0; m_odd = 0; m_done = 0;
    model_clear();
    cmos_hsync = 1'b0;
    cmos_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) drive(16'h0, 1'b0, 1'b0, 1'b0);
    send_frame("post_rst", 1'b1, 2, 4, 1'b0, 1'b0, 1'b0);

    repeat (4) drive(16'h0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cmos_frame_packer.md
Name: cmos_frame_packer

Overview:
Camera-clock-domain front end for the Boson capture path. It takes the buffered 16-bit CMOS pixel bus, arms on a software request, and captures exactly one whole frame between two VSYNC rising edges. It packs pixel pairs into 32-bit words and pushes them with SOF/EOF markers into the CDC FIFO that feeds the streamer Wishbone master. It also keeps the frame/line/word monitors listed in the capture flow-control task list.

Parameters:
CNT_W, 16, width of frame/line/word counters
VSYNC_POL, 1, active level of cmos_vsync_i (1 = high); rising edge means entering the active level
HSYNC_POL, 1, active level of cmos_hsync_i

Ports:
cmos_clk_i  in  1  camera pixel clock; the block's only clock
cmos_rst_i  in  1  asynchronous, active-high reset
cmos_data_i  in  16  pixel data, synchronous to cmos_clk_i
cmos_vsync_i  in  1  frame sync
cmos_hsync_i  in  1  line sync
cmos_valid_i  in  1  pixel qualifier
arm_i  in  1  single-cycle capture request, already synchronised to cmos_clk_i
abort_i  in  1  single-cycle abort, already synchronised
out_dat_o  out  32  packed word: [15:0] = earlier pixel, [31:16] = later pixel
out_sof_o  out  1  first word of frame
out_eof_o  out  1  last word of frame
out_valid_o  out  1  word valid
out_ready_i  in  1  FIFO can accept (i.e. not full)
busy_o  out  1  state is WAIT_SOF or CAPTURE
done_o  out  1  state is DONE
overflow_o  out  1  sticky: a word was dropped
odd_o  out  1  sticky: frame ended with an unpaired pixel
frame_cnt_o  out  CNT_W  free-running count of VSYNC rising edges (wraps)
line_cnt_o  out  CNT_W  HSYNC rising edges in the last captured frame (saturates)
word_cnt_o  out  CNT_W  words pushed in the last captured frame (saturates)

Behaviour:
- Reset: all outputs 0; state IDLE; staging register empty; sync history registers 0.
- Edge detect: vs_rise = active(vsync) & !active(vsync_q). hs_rise is formed the same way. Each rise lasts one cycle.
- FSM:
  - IDLE: arm_i -> WAIT_SOF; clears overflow_o, odd_o, line/word counters.
  - WAIT_SOF: vs_rise -> CAPTURE. The valid pixel on the vs_rise cycle is the first pixel of the frame.
  - CAPTURE:
    - Valid pixel: if the half-word slot is empty, store it in the low half. Otherwise complete the word.
    - A completed word goes to the staging register. If staging was already full, the previous staged word is pushed first (eof=0).
    - Next vs_rise: push staging with eof=1. If a half-word is pending, discard it and set odd_o. Go to DONE.
    - A valid pixel on the terminating vs_rise cycle is dropped.
    - A frame with zero complete words reaches DONE with no push.
  - DONE: arm_i -> WAIT_SOF with counters cleared. Otherwise hold.
  - abort_i in any state -> IDLE. Staging and half-word are discarded, no EOF is emitted, out_valid_o is unaffected. abort_i takes priority over arm_i and vs_rise.
  - arm_i in WAIT_SOF or CAPTURE is ignored.
- SOF: set on the first word pushed after entering CAPTURE. A single-word frame carries SOF and EOF together.
- Output handshake: valid/ready. out_* are held while out_valid_o & !out_ready_i. The output register is free when !out_valid_o | out_ready_i, so push and accept can happen in the same cycle.
- A push while the output register is not free drops the word and sets overflow_o. The dropped word is not counted in word_cnt_o. An EOF that would be dropped also sets overflow_o.
- Latency:
  - A word completed at edge N is staged at N.
  - It is presented after edge M, where M is the next word completion or the terminating vs_rise.
- Counters:
  - line_cnt_o increments on hs_rise in CAPTURE.
  - word_cnt_o increments per successful push.
  - Both saturate at all-ones. frame_cnt_o wraps.

Decomposition:
- Shared package cmos_pkg: CNT_W default, state encoding (IDLE, WAIT_SOF, CAPTURE, DONE), word layout constants (LO_PIX = [15:0], HI_PIX = [31:16]).
- One sub-module: cmos_sync_edge (polarity-configurable registered edge detector), instantiated for VSYNC and HSYNC.

Test Plan:
- Arm, then a 4x2 frame (pixels 0x0001..0x0008) with out_ready_i=1 -> 4 words: 0x00020001 (sof), 0x00040003, 0x00060005, 0x00080007 (eof). line_cnt_o=2, word_cnt_o=4, done_o=1.
- Pixels with no arm -> no pushes, busy_o=0; frame_cnt_o increments on each vs_rise.
- Same frame with out_ready_i=0 throughout -> only the first word is held; overflow_o=1; word_cnt_o=1.
- 5-pixel frame -> 2 words, last with eof; odd_o=1.
- abort_i mid-CAPTURE after 3 pixels -> IDLE, no eof word, busy_o=0. A fresh arm captures the next full frame correctly.
- Valid pixel 0xAAAA on the same cycle as both the starting and terminating vs_rise -> counted in the first frame, dropped in the second. Async reset mid-frame -> all outputs 0 immediately.
